analogue_multichannel_acquisition: RTL
======================================

// Module: analogue_multichannel_acquisition
// PURPOSE
//  Multi-channel analogue acquisition front end: decimates NUM_CH parallel ADC streams (subsample/average/peak),
//  detects an edge trigger on a selected channel and drives a circular sample-memory write port through a
//  pre-trigger / wait / post-trigger capture sequence. Sits between the ADC interface and the capture RAM;
//  generalises the single-channel acquisition block with channel count, decimation modes and capture control.
// PARAMETERS
//  NUM_CH         4   number of analogue channels (1..8)
//  SAMPLE_WIDTH   8   bits per unsigned sample
//  ADDR_WIDTH     10  capture RAM address width; DEPTH = 2**ADDR_WIDTH
//  MAX_DECIM_LOG2 8   largest decimation exponent supported
// PORTS
//  clk          in   1                    system clock
//  rst          in   1                    reset
//  adc_data     in   NUM_CH*SAMPLE_WIDTH  channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//  adc_valid    in   1                    adc_data valid this cycle
//  arm          in   1                    start capture (pulse); latches all configuration inputs
//  force        in   1                    force trigger while waiting (pulse)
//  decim_log2   in   4                    ratio N = 2**decim_log2; values > MAX_DECIM_LOG2 clamp to MAX_DECIM_LOG2
//  decim_mode   in   2                    0 subsample, 1 average, 2 peak max, 3 peak min
//  trig_channel in   3                    trigger source channel; >= NUM_CH selects channel 0
//  trig_level   in   SAMPLE_WIDTH         trigger threshold (unsigned)
//  trig_edge    in   1                    0 rising, 1 falling
//  pre_count    in   ADDR_WIDTH           decimated samples to store before trigger is enabled
//  post_count   in   ADDR_WIDTH           decimated samples to store after the trigger sample
//  wr_en        out  1                    capture RAM write strobe
//  wr_addr      out  ADDR_WIDTH           capture RAM write address
//  wr_data      out  NUM_CH*SAMPLE_WIDTH  decimated samples, same packing as adc_data
//  trigger      out  1                    one-cycle pulse, coincident with wr_en of the trigger sample
//  trig_addr    out  ADDR_WIDTH           address of the trigger sample; held until next arm
//  busy         out  1                    high in PRE, WAIT, POST
//  done         out  1                    high in DONE
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). All outputs 0 on reset; state IDLE.
//  - Decimator: per-channel counter of adc_valid beats; block boundary every N valid beats, counter restarts
//    at arm. Subsample: first sample of block. Average: sum (width SAMPLE_WIDTH+MAX_DECIM_LOG2) >> decim_log2,
//    truncated. Peak: running max/min over block. N=1: all modes pass the sample through unchanged.
//  - Decimated sample produced on the cycle after the adc_valid beat completing a block (latency 1 clk);
//    wr_en/wr_data registered at that point. Decimator idles (no accumulation) in IDLE and DONE.
//  - FSM: IDLE -arm-> PRE (pre_count=0: straight to WAIT). PRE: write; after pre_count writes -> WAIT.
//    WAIT: write; trigger test on each decimated sample -> POST on hit. POST: write; after post_count
//    writes -> DONE (post_count=0: DONE directly after trigger sample). DONE: hold until arm.
//  - arm in any state (incl. mid-capture): restart in PRE, wr_addr=0, decimator and edge history cleared,
//    done=0, trig_addr kept until new trigger.
//  - wr_addr starts at 0 on arm, increments per write, wraps DEPTH-1 -> 0. pre_count+post_count+1 <= DEPTH
//    is caller's responsibility; excess simply overwrites oldest data.
//  - Edge test on trig_channel decimated sample vs previous decimated sample of same channel: rising =
//    prev < trig_level && cur >= trig_level; falling = prev > trig_level && cur <= trig_level. First sample
//    after arm has no history and never triggers. Samples in PRE update history but never trigger.
//  - force in WAIT: next decimated sample is the trigger sample regardless of level. force outside WAIT ignored.
//  - arm and force same cycle: arm wins, force dropped. adc_valid low: no state change except FSM outputs.
// TESTING
//  1. NUM_CH=4, N=1, pre=4, post=3, rising lvl 0x80, ch1 ramp 0x70..0x90 step 4 -> 8 writes addr 0..7,
//     trigger with ch1=0x80 at addr 4, trig_addr=4, done after addr 7.
//  2. decim_log2=2, average, ch0 = 10,20,30,40 -> wr_data ch0=25 one clk after 4th valid; max mode -> 40, min -> 10.
//  3. Falling edge ch2, signal never crosses, force pulsed in WAIT -> trigger on next decimated sample, POST runs.
//  4. ADDR_WIDTH=3, pre=6, level unmet for 5 WAIT samples -> wr_addr wraps 7->0, trigger addr correct after wrap.
//  5. arm reasserted during POST -> busy stays, wr_addr restarts at 0, done stays 0, no stale trigger.
//  6. rst asserted mid-PRE -> next cycle all outputs 0, IDLE; adc_valid ignored until arm.

Source files
------------

// File: rtl/analogue_multichannel_acquisition.sv
// Multi-channel acquisition front end: per-channel decimation, edge trigger on one channel,
// and pre/wait/post capture sequencing onto a circular capture-RAM write port.
module analogue_multichannel_acquisition #(
    parameter int NUM_CH         = 4,
    parameter int SAMPLE_WIDTH   = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_DECIM_LOG2 = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_data,
    input  logic                           adc_valid,
    input  logic                           arm,
    input  logic                           force_trig,
    input  logic [3:0]                     decim_log2,
    input  logic [1:0]                     decim_mode,
    input  logic [2:0]                     trig_channel,
    input  logic [SAMPLE_WIDTH-1:0]        trig_level,
    input  logic                           trig_edge,
    input  logic [ADDR_WIDTH-1:0]          pre_count,
    input  logic [ADDR_WIDTH-1:0]          post_count,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] wr_data,
    output logic                           trigger,
    output logic [ADDR_WIDTH-1:0]          trig_addr,
    output logic                           busy,
    output logic                           done
);
    localparam int SW    = SAMPLE_WIDTH;
    localparam int SUM_W = SAMPLE_WIDTH + MAX_DECIM_LOG2;
    localparam int CW    = MAX_DECIM_LOG2 + 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
    state_t state;

    logic [3:0]            dlog;
    logic [1:0]            mode;
    logic [2:0]            tch;
    logic [SW-1:0]         lvl;
    logic                  falling;
    logic [ADDR_WIDTH-1:0] pre_lat, post_lat, wcnt, next_addr;
    logic [CW-1:0]         dcnt, last_idx;
    logic [SW-1:0]         prev_smp;
    logic                  hist_vld, force_pend;

    logic signed [SUM_W:0] unused_sign;
    logic [SW-1:0]         samp      [NUM_CH];
    logic [SUM_W-1:0]      sum_acc   [NUM_CH];
    logic [SUM_W-1:0]      sum_n     [NUM_CH];
    logic [SW-1:0]         pk_acc    [NUM_CH];
    logic [SW-1:0]         pk_n      [NUM_CH];
    logic [SW-1:0]         first_acc [NUM_CH];
    logic [SW-1:0]         first_n   [NUM_CH];
    logic [SW-1:0]         dec_val   [NUM_CH];
    logic [NUM_CH*SW-1:0]  dec_packed;
    logic [SW-1:0]         trig_cur;
    logic                  active, blk_end, edge_hit, hit;

    function automatic logic [SW-1:0] avg_trunc(input logic [SUM_W-1:0] s, input logic [3:0] sh);
        avg_trunc = SW'(s >> sh);
    endfunction

    function automatic logic [SW-1:0] peak_sel(input logic [1:0] md, input logic [SW-1:0] a,
                                               input logic [SW-1:0] b);
        if (md == 2'd2) peak_sel = (a > b) ? a : b;
        else            peak_sel = (a < b) ? a : b;
    endfunction

    assign unused_sign = '0;
    assign active   = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign last_idx = CW'((32'd1 << dlog) - 32'd1);
    assign blk_end  = active && adc_valid && (dcnt == last_idx);

    // Block result includes the beat that completes it, so the output register sees it one clock later
    always_comb begin
        dec_packed = '0;
        trig_cur   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            samp[c] = adc_data[c*SW +: SW];
            if (dcnt == '0) begin
                sum_n[c]   = SUM_W'(samp[c]);
                pk_n[c]    = samp[c];
                first_n[c] = samp[c];
            end else begin
                sum_n[c]   = sum_acc[c] + SUM_W'(samp[c]);
                pk_n[c]    = peak_sel(mode, samp[c], pk_acc[c]);
                first_n[c] = first_acc[c];
            end
            case (mode)
                2'd0:    dec_val[c] = first_n[c];
                2'd1:    dec_val[c] = avg_trunc(sum_n[c], dlog);
                default: dec_val[c] = pk_n[c];
            endcase
            dec_packed[c*SW +: SW] = dec_val[c];
            if (tch == 3'(c)) trig_cur = dec_val[c];
        end
    end

    assign edge_hit = hist_vld && (falling ? (prev_smp > lvl && trig_cur <= lvl)
                                           : (prev_smp < lvl && trig_cur >= lvl));
    assign hit = edge_hit || force_pend || force_trig;

    always_ff @(posedge clk) begin
        if (active && adc_valid && !arm) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum_acc[c]   <= sum_n[c];
                pk_acc[c]    <= pk_n[c];
                first_acc[c] <= first_n[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trigger    <= 1'b0;
            trig_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dcnt       <= '0;
            wcnt       <= '0;
            next_addr  <= '0;
            hist_vld   <= 1'b0;
            force_pend <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            trigger <= 1'b0;
            if (arm) begin
                dlog       <= (decim_log2 > 4'(MAX_DECIM_LOG2)) ? 4'(MAX_DECIM_LOG2) : decim_log2;
                mode       <= decim_mode;
                tch        <= (int'(trig_channel) >= NUM_CH) ? 3'd0 : trig_channel;
                lvl        <= trig_level;
                falling    <= trig_edge;
                pre_lat    <= pre_count;
                post_lat   <= post_count;
                state      <= (pre_count == '0) ? S_WAIT : S_PRE;
                busy       <= 1'b1;
                done       <= 1'b0;
                dcnt       <= '0;
                wcnt       <= '0;
                next_addr  <= '0;
                wr_addr    <= '0;
                hist_vld   <= 1'b0;
                force_pend <= 1'b0;
            end else begin
                if (state == S_WAIT && force_trig) force_pend <= 1'b1;
                if (active && adc_valid) dcnt <= blk_end ? '0 : CW'(dcnt + 1'b1);
                if (blk_end) begin
                    wr_en     <= 1'b1;
                    wr_data   <= dec_packed;
                    wr_addr   <= next_addr;
                    next_addr <= ADDR_WIDTH'(next_addr + 1'b1);
                    prev_smp  <= trig_cur;
                    hist_vld  <= 1'b1;
                    case (state)
                        S_PRE: begin
                            if (wcnt == ADDR_WIDTH'(pre_lat - 1'b1)) begin
                                state <= S_WAIT;
                                wcnt  <= '0;
                            end else begin
                                wcnt <= ADDR_WIDTH'(wcnt + 1'b1);
                            end
                        end
                        S_WAIT: begin
                            if (hit) begin
                                trigger    <= 1'b1;
                                trig_addr  <= next_addr;
                                force_pend <= 1'b0;
                                wcnt       <= '0;
                                if (post_lat == '0) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_POST;
                                end
                            end
                        end
                        S_POST: begin
                            if (wcnt == ADDR_WIDTH'(post_lat - 1'b1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                wcnt <= ADDR_WIDTH'(wcnt + 1'b1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
